// File: rtl/pe_alu_pkg.sv
// Shared types and constants for the pipelined PE ALU.
// Op encodings, op_code field positions and the pipe payload struct.
package pe_alu_pkg;

    typedef enum logic [5:0] {
        OpAdd    = 6'h00,
        OpSub    = 6'h01,
        OpAbs    = 6'h03,
        OpGteMax = 6'h04,
        OpLteMin = 6'h05,
        OpEq     = 6'h06,
        OpSel    = 6'h08,
        OpMult0  = 6'h0B,
        OpMult1  = 6'h0C,
        OpMult2  = 6'h0D,
        OpRelu   = 6'h0E,
        OpRshft  = 6'h0F,
        OpLshft  = 6'h11,
        OpOr     = 6'h12,
        OpAnd    = 6'h13,
        OpXor    = 6'h14
    } pe_op_e;

    localparam int unsigned PE_SIGNED_BIT = 6;
    localparam int unsigned PE_ACC_BIT    = 7;

    // Payload is sized for the widest supported datapath; narrower units use the low bits.
    localparam int unsigned PE_MAX_WIDTH  = 64;

    typedef struct packed {
        logic [PE_MAX_WIDTH-1:0] res;
        logic                    res_p;
    } pe_res_t;

endpackage

// File: rtl/pe_alu_comb.sv
// Combinational PE operation datapath: computes result and flag for one operand bundle.
// Signedness affects compare, multiply, arithmetic right shift and ABS only.
module pe_alu_comb
    import pe_alu_pkg::*;
#(
    parameter int unsigned DataWidth = 16
) (
    input  logic [5:0]           op,
    input  logic                 is_signed,
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic                 d_p,
    output logic [DataWidth-1:0] res,
    output logic                 res_p
);

    localparam int unsigned Half = DataWidth / 2;
    localparam int unsigned ShW  = $clog2(DataWidth);
    localparam int unsigned W2   = 2 * DataWidth;

    logic [DataWidth:0]          add_sum;
    logic [DataWidth:0]          sub_sum;
    logic signed [DataWidth-1:0] a_s;
    logic signed [DataWidth-1:0] b_s;
    logic                        a_ge_b;
    logic                        a_le_b;
    logic [ShW-1:0]              sh;
    logic [DataWidth-1:0]        srl_res;
    logic [DataWidth-1:0]        sra_res;
    logic [DataWidth-1:0]        sll_res;
    logic [DataWidth-1:0]        neg_a;
    logic [W2-1:0]               a_ext;
    logic [W2-1:0]               b_ext;
    logic [W2-1:0]               prod;
    logic                        mult_ovf;

    assign add_sum = {1'b0, a} + {1'b0, b} + {{DataWidth{1'b0}}, d_p};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{DataWidth{1'b0}}, 1'b1};

    // Keep signed views in separate nets so a mixed ?: never demotes them to unsigned.
    assign a_s    = a;
    assign b_s    = b;
    assign a_ge_b = is_signed ? (a_s >= b_s) : (a >= b);
    assign a_le_b = is_signed ? (a_s <= b_s) : (a <= b);

    assign sh      = b[ShW-1:0];
    assign srl_res = a >> sh;
    assign sra_res = a_s >>> sh;
    assign sll_res = a << sh;
    assign neg_a   = ~a + {{(DataWidth-1){1'b0}}, 1'b1};

    // Extending to 2*DataWidth makes a plain multiply exact for both signednesses.
    assign a_ext = is_signed ? {{DataWidth{a[DataWidth-1]}}, a} : {{DataWidth{1'b0}}, a};
    assign b_ext = is_signed ? {{DataWidth{b[DataWidth-1]}}, b} : {{DataWidth{1'b0}}, b};
    assign prod  = a_ext * b_ext;

    assign mult_ovf = is_signed ? (prod[W2-1:DataWidth] != {DataWidth{prod[DataWidth-1]}})
                                : (|prod[W2-1:DataWidth]);

    always_comb begin
        res   = a;
        res_p = d_p;
        case (op)
            OpAdd: begin
                res   = add_sum[DataWidth-1:0];
                res_p = add_sum[DataWidth];
            end
            OpSub: begin
                res   = sub_sum[DataWidth-1:0];
                res_p = sub_sum[DataWidth];
            end
            OpAbs: begin
                res   = (is_signed && a[DataWidth-1]) ? neg_a : a;
                res_p = a[DataWidth-1];
            end
            OpGteMax: begin
                res_p = a_ge_b;
                res   = a_ge_b ? a : b;
            end
            OpLteMin: begin
                res_p = a_le_b;
                res   = a_le_b ? a : b;
            end
            OpEq: begin
                res_p = (a == b);
                res   = b;
            end
            OpSel: begin
                res   = d_p ? a : b;
                res_p = 1'b0;
            end
            OpMult0: begin
                res   = prod[DataWidth-1:0];
                res_p = mult_ovf;
            end
            OpMult1: begin
                res   = prod[Half +: DataWidth];
                res_p = mult_ovf;
            end
            OpMult2: begin
                res   = prod[W2-1:DataWidth];
                res_p = mult_ovf;
            end
            OpRelu: begin
                res   = a[DataWidth-1] ? '0 : a;
                res_p = a[DataWidth-1];
            end
            OpRshft: begin
                res   = is_signed ? sra_res : srl_res;
                res_p = 1'b0;
            end
            OpLshft: begin
                res   = sll_res;
                res_p = 1'b0;
            end
            OpOr: begin
                res   = a | b;
                res_p = 1'b0;
            end
            OpAnd: begin
                res   = a & b;
                res_p = 1'b0;
            end
            OpXor: begin
                res   = a ^ b;
                res_p = 1'b0;
            end
            default: begin
                res   = a;
                res_p = d_p;
            end
        endcase
    end

endmodule

// File: rtl/pe_alu_pipe.sv
// Pipelined PE compute unit: computes at acceptance, then carries the result through
// NumStages back-pressurable register stages. Also owns the accumulator.
module pe_alu_pipe
    import pe_alu_pkg::*;
#(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned NumStages = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8:0]           op_code,
    input  logic [DataWidth-1:0] op_a,
    input  logic [DataWidth-1:0] op_b,
    input  logic                 op_d_p,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] res,
    output logic                 res_p,
    output logic [DataWidth-1:0] acc
);

    logic                 advance;
    logic                 accept;
    logic [DataWidth-1:0] acc_q;
    logic [DataWidth-1:0] op_a_eff;
    logic [DataWidth-1:0] alu_res;
    logic                 alu_res_p;
    pe_res_t              stage_d;
    logic [NumStages-1:0] valid_q;
    pe_res_t              data_q [NumStages];
    logic                 unused_bits;

    // The whole pipe moves as one; any stall at the output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    assign op_a_eff = op_code[PE_ACC_BIT] ? acc_q : op_a;

    pe_alu_comb #(
        .DataWidth (DataWidth)
    ) u_alu (
        .op        (op_code[5:0]),
        .is_signed (op_code[PE_SIGNED_BIT]),
        .a         (op_a_eff),
        .b         (op_b),
        .d_p       (op_d_p),
        .res       (alu_res),
        .res_p     (alu_res_p)
    );

    always_comb begin
        stage_d                      = '0;
        stage_d.res[DataWidth-1:0]   = alu_res;
        stage_d.res_p                = alu_res_p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NumStages; i++) begin
                data_q[i] <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= accept;
            data_q[0]  <= stage_d;
            for (int i = 1; i < NumStages; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    // Accumulator updates at acceptance so the next bundle sees it with no hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (accept && op_code[PE_ACC_BIT]) begin
            acc_q <= alu_res;
        end
    end

    assign out_valid = valid_q[NumStages-1];
    assign res       = data_q[NumStages-1].res[DataWidth-1:0];
    assign res_p     = data_q[NumStages-1].res_p;
    assign acc       = acc_q;

    assign unused_bits = ^{op_code[8], data_q[NumStages-1].res[PE_MAX_WIDTH-1:DataWidth]};

endmodule

// File: tb/tb_pe_alu_pipe.sv
// Randomised and directed bench for pe_alu_pipe against an arithmetic reference model
// with an in-order scoreboard of expected results.
module tb_pe_alu_pipe;

    localparam int DW = 16;
    localparam int NS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [8:0]    op_code = '0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          op_d_p = 1'b0;
    logic          acc_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] res;
    logic          res_p;
    logic [DW-1:0] acc;

    always #5 clk = ~clk;

    pe_alu_pipe #(
        .DataWidth (DW),
        .NumStages (NS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_d_p    (op_d_p),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_p     (res_p),
        .acc       (acc)
    );

    int            n_checks = 0;
    int            n_fails = 0;
    logic [16:0]   exp_q[$];
    logic [16:0]   fire_log[$];
    logic [15:0]   acc_m = '0;
    logic          fired;
    logic [16:0]   fired_val;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [16:0] model(input logic [5:0] op, input logic sgn,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic dp);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = sgn ? longint'($signed(a)) : longint'(a);
        longint sb = sgn ? longint'($signed(b)) : longint'(b);
        longint r;
        longint pr;
        int     sh = int'(b[3:0]);
        logic   p;
        case (op)
            6'h00: begin r = ua + ub + longint'(dp); p = (r > 65535); end
            6'h01: begin r = ua + (ub ^ 65535) + 1; p = (r > 65535); end
            6'h03: begin r = (sgn && sa < 0) ? -sa : ua; p = a[15]; end
            6'h04: begin p = (sa >= sb); r = p ? ua : ub; end
            6'h05: begin p = (sa <= sb); r = p ? ua : ub; end
            6'h06: begin p = (ua == ub); r = ub; end
            6'h08: begin r = dp ? ua : ub; p = 1'b0; end
            6'h0B, 6'h0C, 6'h0D: begin
                pr = sa * sb;
                r  = (op == 6'h0B) ? pr : (op == 6'h0C) ? (pr >>> 8) : (pr >>> 16);
                p  = sgn ? (pr < -32768 || pr > 32767) : (pr > 65535);
            end
            6'h0E: begin r = a[15] ? 0 : ua; p = a[15]; end
            6'h0F: begin r = sgn ? (sa >>> sh) : (ua >> sh); p = 1'b0; end
            6'h11: begin r = ua << sh; p = 1'b0; end
            6'h12: begin r = ua | ub; p = 1'b0; end
            6'h13: begin r = ua & ub; p = 1'b0; end
            6'h14: begin r = ua ^ ub; p = 1'b0; end
            default: begin r = ua; p = dp; end
        endcase
        return {p, r[15:0]};
    endfunction

    // One clock cycle: check acc, drive inputs, score any fire and any acceptance.
    task automatic cycle(input logic iv, input logic [8:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic dp, input logic clr,
                         input logic ordy);
        logic [16:0] e;
        logic [15:0] a_eff;
        logic        acc_in;
        @(negedge clk);
        check_eq("acc", acc, acc_m);
        in_valid  = iv;
        op_code   = opc;
        op_a      = a;
        op_b      = b;
        op_d_p    = dp;
        acc_clr   = clr;
        out_ready = ordy;
        #1;
        fired  = out_valid && out_ready;
        acc_in = 1'b0;
        e      = '0;
        if (fired) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("res", res, e[15:0]);
                check_eq("res_p", res_p, e[16]);
                fired_val = {res_p, res};
                fire_log.push_back({res_p, res});
            end
        end
        if (iv && in_ready) begin
            a_eff  = opc[7] ? acc_m : a;
            e      = model(opc[5:0], opc[6], a_eff, b, dp);
            acc_in = opc[7];
            exp_q.push_back(e);
        end
        if (clr) acc_m = '0;
        else if (acc_in) acc_m = e[15:0];
    endtask

    task automatic idle();
        cycle(1'b0, 9'h000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle();
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run_one(input string tag, input logic [8:0] opc, input logic [15:0] a,
                           input logic [15:0] b, input logic dp,
                           input logic [15:0] exp_res, input logic exp_p);
        int lat = 0;
        fired_val = '1;
        cycle(1'b1, opc, a, b, dp, 1'b0, 1'b1);
        do begin
            idle();
            lat++;
        end while (!fired && lat <= 20);
        check_eq({tag, "_latency"}, lat, NS);
        check_eq({tag, "_res"}, fired_val[15:0], exp_res);
        check_eq({tag, "_res_p"}, fired_val[16], exp_p);
    endtask

    logic [5:0] ops [16] = '{6'h00, 6'h01, 6'h03, 6'h04, 6'h05, 6'h06, 6'h08, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h11, 6'h12, 6'h13, 6'h14};

    initial begin
        // Reset state
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_res", res, 0);
        check_eq("rst_res_p", res_p, 0);
        check_eq("rst_acc", acc, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("add", 9'h000, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0);
        run_one("gte_s", 9'h044, 16'hFFFE, 16'h0003, 1'b0, 16'h0003, 1'b0);
        run_one("gte_u", 9'h004, 16'hFFFE, 16'h0003, 1'b0, 16'hFFFE, 1'b1);
        run_one("mul0_s", 9'h04B, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1);
        run_one("mul2_s", 9'h04D, 16'h0100, 16'h0100, 1'b0, 16'h0001, 1'b1);

        // Accumulate ADD, four back-to-back bundles
        fire_log.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 9'h080, 16'h1234, 16'd5, 1'b0, 1'b0, 1'b1);
        drain();
        check_eq("acc_count", fire_log.size(), 4);
        for (int i = 0; i < 4 && i < fire_log.size(); i++)
            check_eq("acc_seq", fire_log[i][15:0], 32'(5 * (i + 1)));
        @(negedge clk);
        check_eq("acc_20", acc, 16'd20);
        cycle(1'b0, 9'h000, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_eq("acc_cleared", acc, 0);

        // Back-pressure: hold out_ready low with bundles queued behind the stall
        fire_log.delete();
        cycle(1'b1, 9'h000, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 9'h014, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 9'h080, 16'h0, 16'd7, 1'b0, 1'b0, 1'b0);
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_res", res, 16'd3);
        end
        cycle(1'b1, 9'h080, 16'h0, 16'd7, 1'b0, 1'b0, 1'b1);
        drain();
        check_eq("stall_count", fire_log.size(), 3);
        if (fire_log.size() == 3) begin
            check_eq("stall_ord0", fire_log[0][15:0], 16'd3);
            check_eq("stall_ord1", fire_log[1][15:0], 16'hFF00);
            check_eq("stall_ord2", fire_log[2][15:0], 16'd7);
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [8:0] opc;
            logic [15:0] a;
            logic [15:0] b;
            opc[5:0] = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 15)]
                                                  : 6'($urandom_range(0, 63));
            opc[6] = 1'($urandom_range(0, 1));
            opc[7] = ($urandom_range(0, 3) == 0);
            opc[8] = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
            cycle($urandom_range(0, 3) != 0, opc, a, b, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset mid-stream
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 9'h080, 16'h0, 16'($urandom), 1'b0, 1'b0, i < 2);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_acc", acc, 0);
        exp_q.delete();
        acc_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_one("post_rst", 9'h000, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
